// File: rtl/timer_pkg.sv
// Shared types and helpers for the multi-channel timer.
// Channel state encoding and count bus slicing.
package timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

  // LSB of channel k inside a packed count bus.
  function automatic int unsigned ch_lsb(
    input int unsigned k,
    input int unsigned w
  );
    return k * w;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: IDLE/RUN FSM with reload.
// Stop beats start, start beats tick.
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             periodic_i,
  input  logic [WIDTH-1:0] load_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             done_o,
  output logic             expired_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  ch_state_e        state_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] reload_q;
  logic             per_q;
  logic             exp_q;

  // Channel FSM, counter and registered expiry pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      per_q    <= 1'b0;
      exp_q    <= 1'b0;
    end else begin
      exp_q <= 1'b0;
      if (stop_i) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else if (start_i) begin
        reload_q <= load_i;
        if (load_i == '0) begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          per_q   <= 1'b0;
          exp_q   <= 1'b1;
        end else begin
          state_q <= ST_RUN;
          cnt_q   <= load_i;
          per_q   <= periodic_i;
        end
      end else if (tick_i &&
                   state_q == ST_RUN) begin
        if (cnt_q == ONE) begin
          exp_q <= 1'b1;
          if (per_q) begin
            cnt_q <= reload_q;
          end else begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        end else begin
          cnt_q <= cnt_q - ONE;
        end
      end
    end
  end

  assign cnt_o     = cnt_q;
  assign done_o    = (state_q == ST_IDLE);
  assign expired_o = exp_q;

endmodule

// File: rtl/multi_timer.sv
// NUM_CH countdown timers sharing one prescaler.
// Prescaler free-runs; channels are independent.
module multi_timer
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DIV_W  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [DIV_W-1:0]        div_i,
  input  logic [NUM_CH-1:0]       start_i,
  input  logic [NUM_CH-1:0]       stop_i,
  input  logic [NUM_CH-1:0]       periodic_i,
  input  logic [NUM_CH*WIDTH-1:0] count_i,
  output logic [NUM_CH*WIDTH-1:0] count_o,
  output logic [NUM_CH-1:0]       done_o,
  output logic [NUM_CH-1:0]       expired_o,
  output logic                    expired_any_o
);

  logic [DIV_W-1:0] pre_q;
  logic [DIV_W-1:0] pre_d;
  logic             tick;

  // >= so a lowered divisor ticks at once
  assign tick  = (pre_q >= div_i);
  assign pre_d = tick ? '0
                      : pre_q + DIV_W'(1);

  // Free-running prescaler.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    timer_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .tick_i    (tick),
      .start_i   (start_i[k]),
      .stop_i    (stop_i[k]),
      .periodic_i(periodic_i[k]),
      .load_i    (count_i[ch_lsb(k, WIDTH) +: WIDTH]),
      .cnt_o     (count_o[ch_lsb(k, WIDTH) +: WIDTH]),
      .done_o    (done_o[k]),
      .expired_o (expired_o[k])
    );
  end

  assign expired_any_o = |expired_o;

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer.
// Spec-level model checked every falling edge.
module tb_multi_timer;

  localparam int W  = 8;
  localparam int NC = 4;
  localparam int DW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [DW-1:0]   div_i = '0;
  logic [NC-1:0]   start_i = '0;
  logic [NC-1:0]   stop_i = '0;
  logic [NC-1:0]   periodic_i = '0;
  logic [NC*W-1:0] count_i = '0;
  logic [NC*W-1:0] count_o;
  logic [NC-1:0]   done_o;
  logic [NC-1:0]   expired_o;
  logic            expired_any_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  multi_timer #(
    .WIDTH(W), .NUM_CH(NC), .DIV_W(DW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .div_i        (div_i),
    .start_i      (start_i),
    .stop_i       (stop_i),
    .periodic_i   (periodic_i),
    .count_i      (count_i),
    .count_o      (count_o),
    .done_o       (done_o),
    .expired_o    (expired_o),
    .expired_any_o(expired_any_o)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string nm,
                       input logic [63:0] got,
                       input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               nm, got, want, $time);
    end
  endtask

  // Model: remaining ticks per channel; 0 = idle.
  int  m_left [NC];
  int  m_rel  [NC];
  bit  m_per  [NC];
  bit  m_exp  [NC];
  int  m_since = 0;

  initial begin
    for (int k = 0; k < NC; k++) begin
      m_left[k] = 0; m_rel[k] = 0;
      m_per[k] = 0; m_exp[k] = 0;
    end
  end

  initial forever begin
    bit tk;
    int n;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_since = 0;
      for (int k = 0; k < NC; k++) begin
        m_left[k] = 0; m_rel[k] = 0;
        m_per[k] = 0; m_exp[k] = 0;
      end
    end else begin
      // a tick comes once div_i+1 cycles have elapsed
      tk = (m_since >= int'(div_i));
      m_since = tk ? 0 : m_since + 1;
      for (int k = 0; k < NC; k++) begin
        m_exp[k] = 0;
        n = int'(count_i[k*W +: W]);
        if (stop_i[k]) begin
          m_left[k] = 0;
        end else if (start_i[k]) begin
          m_rel[k] = n;
          m_left[k] = n;
          m_per[k] = periodic_i[k] && n != 0;
          if (n == 0) m_exp[k] = 1;
        end else if (tk && m_left[k] > 0) begin
          m_left[k]--;
          if (m_left[k] == 0) begin
            m_exp[k] = 1;
            if (m_per[k]) m_left[k] = m_rel[k];
          end
        end
      end
    end
  end

  // Compare DUT against model on each falling edge.
  initial forever begin
    bit any;
    @(negedge clk);
    any = 0;
    for (int k = 0; k < NC; k++) begin
      check($sformatf("cnt%0d", k),
            64'(count_o[k*W +: W]),
            64'(m_left[k]));
      check($sformatf("done%0d", k),
            64'(done_o[k]), 64'(m_left[k] == 0));
      check($sformatf("exp%0d", k),
            64'(expired_o[k]), 64'(m_exp[k]));
      any |= m_exp[k];
    end
    check("exp_any", 64'(expired_any_o), 64'(any));
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_n(input int k, input int v);
    count_i[k*W +: W] = W'(v);
  endtask

  task automatic wait_exp(input int k,
                          input int maxc,
                          output int at);
    at = -1000;
    for (int i = 0; i < maxc; i++) begin
      step();
      if (expired_o[k]) begin
        at = cyc;
        break;
      end
    end
  endtask

  function automatic int chv(input int k);
    return int'(count_o[k*W +: W]);
  endfunction

  initial begin
    int e0, at, prev, np;
    bit seen;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("rst_done", done_o, 4'hF);
    check("rst_cnt", count_o, 0);
    check("rst_exp", expired_o, 0);
    check("rst_any", expired_any_o, 0);

    // reset mid-run
    set_n(0, 10);
    start_i = 4'b0001;
    step();
    start_i = '0;
    repeat (3) step();
    check("mid_cnt0", chv(0), 7);
    rst_n = 1'b0;
    #1;
    check("arst_done", done_o, 4'hF);
    check("arst_cnt", count_o, 0);
    step(); step();
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      step();
      if (expired_any_o) seen = 1;
    end
    check("arst_nopulse", seen, 0);

    // one-shot ch0 N=5
    set_n(0, 5);
    start_i = 4'b0001;
    step();
    e0 = cyc;
    start_i = '0;
    check("os_load", chv(0), 5);
    check("os_busy", done_o[0], 0);
    wait_exp(0, 20, at);
    check("os_lat", at - e0, 5);
    check("os_done", done_o[0], 1);
    step();
    check("os_pulse1", expired_o[0], 0);

    // periodic ch1 N=3
    set_n(1, 3);
    periodic_i = 4'b0010;
    start_i = 4'b0010;
    step();
    e0 = cyc;
    start_i = '0;
    periodic_i = '0;
    wait_exp(1, 10, at);
    check("per_lat", at - e0, 3);
    for (int i = 0; i < 2; i++) begin
      prev = at;
      wait_exp(1, 10, at);
      check("per_period", at - prev, 3);
    end
    stop_i = 4'b0010;
    step();
    stop_i = '0;
    check("per_stop_cnt", chv(1), 0);
    check("per_stop_done", done_o[1], 1);
    np = 0;
    repeat (10) begin
      step();
      if (expired_o[1]) np++;
    end
    check("per_stop_np", np, 0);

    // prescaled ch2 N=2, div=3
    div_i = 4'd3;
    set_n(2, 2);
    start_i = 4'b0100;
    step();
    e0 = cyc;
    start_i = '0;
    wait_exp(2, 20, at);
    check("div_lat_rng",
          (at - e0 >= 5) && (at - e0 <= 8), 1);
    div_i = '0;
    step();

    // N=0 with periodic requested
    set_n(2, 0);
    periodic_i = 4'b0100;
    start_i = 4'b0100;
    step();
    start_i = '0;
    periodic_i = '0;
    check("n0_exp", expired_o[2], 1);
    check("n0_done", done_o[2], 1);
    check("n0_any", expired_any_o, 1);
    np = 0;
    repeat (6) begin
      step();
      if (expired_o[2]) np++;
    end
    check("n0_single", np, 0);

    // start and stop together
    set_n(3, 4);
    start_i = 4'b1000;
    stop_i = 4'b1000;
    step();
    start_i = '0;
    stop_i = '0;
    check("ss_done", done_o[3], 1);
    check("ss_cnt", chv(3), 0);
    check("ss_exp", expired_o[3], 0);
    step();
    check("ss_exp2", expired_o[3], 0);

    // restart ch3 at cnt=2 with N=7
    start_i = 4'b1000;
    step();
    start_i = '0;
    step(); step();
    check("rs_at2", chv(3), 2);
    set_n(3, 7);
    start_i = 4'b1000;
    step();
    e0 = cyc;
    start_i = '0;
    check("rs_load", chv(3), 7);
    wait_exp(3, 20, at);
    check("rs_lat", at - e0, 7);

    // simultaneous expiry ch0 and ch3
    set_n(0, 6);
    set_n(3, 6);
    start_i = 4'b1001;
    step();
    e0 = cyc;
    start_i = '0;
    wait_exp(0, 20, at);
    check("sim_lat", at - e0, 6);
    check("sim_exp3", expired_o[3], 1);
    check("sim_any", expired_any_o, 1);
    check("sim_vec", expired_o, 4'b1001);
    step();
    check("sim_any_off", expired_any_o, 0);

    repeat (4) step();
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
